// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv window sequencing blocks.
package conv_pkg;

    localparam int DEF_DIM_W     = 16;
    localparam int DEF_CNT_W     = 32;
    localparam int DEF_MAX_WIDTH = 8192;
    localparam int MIN_DIM       = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// Column/row position tracker over a latched frame size, with last-pixel detect.
// Geometry is captured on i_load so live config changes never disturb a running frame.
module frame_pos_counter
    import conv_pkg::*;
#(
    parameter int DIM_W = DEF_DIM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIM_W-1:0] i_width,
    input  logic [DIM_W-1:0] i_height,
    input  logic             i_advance,
    output logic [DIM_W-1:0] o_col,
    output logic [DIM_W-1:0] o_row,
    output logic [DIM_W-1:0] o_width,
    output logic             o_last
);

    logic [DIM_W-1:0] r_width;
    logic [DIM_W-1:0] r_height;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_row;
    logic             w_col_end;

    assign w_col_end = (r_col == r_width - DIM_W'(1));
    assign o_last    = w_col_end && (r_row == r_height - DIM_W'(1));
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_width   = r_width;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width  <= '0;
            r_height <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (i_load) begin
            r_width  <= i_width;
            r_height <= i_height;
            r_col    <= '0;
            r_row    <= '0;
        end else if (i_advance) begin
            if (o_last) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencer for the 3x3 conv window: clear, stream, window-valid tracking.
// Pixels are written in the same cycle they are accepted; window flags follow one cycle later.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int DIM_W     = DEF_DIM_W,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             cfg_stride2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lb_data_valid,
    output logic             lb_rst,
    output logic [CNT_W-1:0] lb_width,
    output logic             win_valid,
    output logic [DIM_W-1:0] win_row,
    output logic [DIM_W-1:0] win_col,
    output logic [CNT_W-1:0] win_count,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    ctrl_state_t      r_state;
    logic             r_stride2;
    logic             r_win_valid;
    logic [DIM_W-1:0] r_win_row;
    logic [DIM_W-1:0] r_win_col;
    logic [CNT_W-1:0] r_win_count;
    logic             r_frame_done;
    logic             r_cfg_err;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_cfg_ok;
    logic             w_load;
    logic [DIM_W-1:0] w_col;
    logic [DIM_W-1:0] w_row;
    logic [DIM_W-1:0] w_width;
    logic             w_last;
    logic [DIM_W-1:0] w_row_m2;
    logic [DIM_W-1:0] w_col_m2;
    logic             w_hit;

    assign w_cfg_ok = (cfg_width >= DIM_W'(MIN_DIM))
                   && (CNT_W'(cfg_width) <= CNT_W'(MAX_WIDTH))
                   && (cfg_height >= DIM_W'(MIN_DIM));
    assign w_load     = (r_state == IDLE) && start && w_cfg_ok;
    assign w_in_ready = (r_state == STREAM);
    assign w_accept   = in_valid && w_in_ready;

    frame_pos_counter #(
        .DIM_W(DIM_W)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_width  (cfg_width),
        .i_height (cfg_height),
        .i_advance(w_accept),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_width  (w_width),
        .o_last   (w_last)
    );

    // With stride 2, only even offsets from the first full window are kept.
    assign w_row_m2 = w_row - DIM_W'(2);
    assign w_col_m2 = w_col - DIM_W'(2);
    assign w_hit    = (w_row >= DIM_W'(2)) && (w_col >= DIM_W'(2))
                   && (!r_stride2 || (!w_row_m2[0] && !w_col_m2[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_stride2    <= 1'b0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_win_count  <= '0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_stride2   <= cfg_stride2;
                            r_win_count <= '0;
                            r_state     <= CLEAR;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                CLEAR: r_state <= STREAM;
                STREAM: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_win_valid <= 1'b1;
                            r_win_row   <= w_row_m2 >> r_stride2;
                            r_win_col   <= w_col_m2 >> r_stride2;
                            r_win_count <= r_win_count + CNT_W'(1);
                        end
                        if (w_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = w_in_ready;
    assign lb_data_valid = w_accept;
    assign lb_rst        = (r_state == CLEAR);
    assign lb_width      = CNT_W'(w_width);
    assign busy          = (r_state != IDLE);
    assign win_valid     = r_win_valid;
    assign win_row       = r_win_row;
    assign win_col       = r_win_col;
    assign win_count     = r_win_count;
    assign frame_done    = r_frame_done;
    assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: frame table with a window scoreboard, config rejects, reset abort.
module tb_conv_window_ctrl;

    localparam int DIM_W = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic             cfg_stride2;
    logic             in_valid;
    logic             in_ready;
    logic             lb_data_valid;
    logic             lb_rst;
    logic [CNT_W-1:0] lb_width;
    logic             win_valid;
    logic [DIM_W-1:0] win_row;
    logic [DIM_W-1:0] win_col;
    logic [CNT_W-1:0] win_count;
    logic             busy;
    logic             frame_done;
    logic             cfg_err;

    always #5 clk = ~clk;

    conv_window_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_stride2  (cfg_stride2),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .lb_data_valid(lb_data_valid),
        .lb_rst       (lb_rst),
        .lb_width     (lb_width),
        .win_valid    (win_valid),
        .win_row      (win_row),
        .win_col      (win_col),
        .win_count    (win_count),
        .busy         (busy),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    typedef struct {
        int w;
        int h;
        int s;
        int gap;
        int disturb;
        int exp_win;
    } frame_vec_t;

    typedef struct {
        int r;
        int c;
    } win_t;

    typedef struct {
        int w;
        int h;
    } bad_cfg_t;

    win_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    frame_vec_t frames[8];
    bad_cfg_t   bads[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input frame_vec_t v, input string tag);
        int   r = 0;
        int   c = 0;
        int   nwin = 0;
        int   npix;
        logic hit;
        win_t e;
        npix        = v.w * v.h;
        cfg_width   = DIM_W'(v.w);
        cfg_height  = DIM_W'(v.h);
        cfg_stride2 = (v.s != 0);
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " lb_rst in CLEAR"}, lb_rst, 1);
        chk({tag, " busy in CLEAR"}, busy, 1);
        chk({tag, " in_ready in CLEAR"}, in_ready, 0);
        chk({tag, " lb_width"}, lb_width, v.w);
        tick();
        chk({tag, " lb_rst after CLEAR"}, lb_rst, 0);
        for (int p = 0; p < npix; p++) begin
            if (v.gap != 0 && p > 0) begin
                in_valid = 1'b0;
                #1;
                chk({tag, " lb_data_valid idle"}, lb_data_valid, 0);
                tick();
                chk({tag, " win_valid idle"}, win_valid, 0);
            end
            if (v.disturb != 0 && p == 5) begin
                start      = 1'b1;
                cfg_width  = DIM_W'(7);
                cfg_height = DIM_W'(3);
            end
            in_valid = 1'b1;
            #1;
            chk({tag, " in_ready streaming"}, in_ready, 1);
            chk({tag, " lb_data_valid accept"}, lb_data_valid, 1);
            hit = (r >= 2) && (c >= 2) &&
                  (v.s == 0 || (((r - 2) % 2) == 0 && ((c - 2) % 2) == 0));
            if (hit) begin
                nwin++;
                exp_q.push_back('{(r - 2) >> v.s, (c - 2) >> v.s});
            end
            tick();
            start = 1'b0;
            chk({tag, " win_valid timing"}, win_valid, hit);
            if (win_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected window"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " win_row"}, win_row, e.r);
                    chk({tag, " win_col"}, win_col, e.c);
                    chk({tag, " win_count running"}, win_count, nwin);
                end
            end
            chk({tag, " frame_done"}, frame_done, (p == npix - 1));
            if (c == v.w - 1) begin
                c = 0;
                r++;
            end else begin
                c++;
            end
        end
        in_valid = 1'b0;
        chk({tag, " in_ready in DONE"}, in_ready, 0);
        chk({tag, " win_count total"}, win_count, v.exp_win);
        chk({tag, " windows left over"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
        chk({tag, " busy after frame"}, busy, 0);
        chk({tag, " frame_done pulse end"}, frame_done, 0);
        chk({tag, " win_valid after frame"}, win_valid, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " lb_data_valid"}, lb_data_valid, 0);
        chk({tag, " lb_rst"}, lb_rst, 0);
        chk({tag, " lb_width"}, lb_width, 0);
        chk({tag, " win_valid"}, win_valid, 0);
        chk({tag, " win_row"}, win_row, 0);
        chk({tag, " win_col"}, win_col, 0);
        chk({tag, " win_count"}, win_count, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        // w, h, stride2, gap, disturb, expected windows
        frames[0] = '{4, 4, 0, 0, 0, 4};
        frames[1] = '{5, 5, 1, 0, 0, 4};
        frames[2] = '{4, 3, 0, 1, 0, 2};
        frames[3] = '{4, 4, 0, 0, 1, 4};
        frames[4] = '{3, 3, 0, 0, 0, 1};
        frames[5] = '{8, 5, 0, 0, 0, 18};
        frames[6] = '{6, 7, 1, 0, 0, 6};
        frames[7] = '{4, 4, 1, 1, 0, 1};
        bads[0]   = '{2, 4};
        bads[1]   = '{8193, 4};
        bads[2]   = '{4, 2};

        rst         = 1'b1;
        start       = 1'b0;
        cfg_width   = '0;
        cfg_height  = '0;
        cfg_stride2 = 1'b0;
        in_valid    = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_frame(frames[i], $sformatf("frame%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            cfg_width  = DIM_W'(bads[i].w);
            cfg_height = DIM_W'(bads[i].h);
            start      = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("bad%0d cfg_err", i), cfg_err, 1);
            chk($sformatf("bad%0d busy", i), busy, 0);
            chk($sformatf("bad%0d in_ready", i), in_ready, 0);
            tick();
            chk($sformatf("bad%0d cfg_err pulse end", i), cfg_err, 0);
            chk($sformatf("bad%0d busy later", i), busy, 0);
        end

        // Largest legal width is accepted, then abandoned by reset.
        cfg_width  = DIM_W'(8192);
        cfg_height = DIM_W'(3);
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("maxw cfg_err", cfg_err, 0);
        chk("maxw busy", busy, 1);
        chk("maxw lb_width", lb_width, 8192);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("maxw busy after rst", busy, 0);

        // Mid-frame reset after 7 accepts of a 4x4 frame.
        cfg_width   = DIM_W'(4);
        cfg_height  = DIM_W'(4);
        cfg_stride2 = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("abort no window yet", win_valid, 0);
        end
        rst = 1'b1;
        tick();
        chk_all_zero("abort");
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("abort no frame_done", frame_done, 0);
        chk("abort busy", busy, 0);
        tick();
        chk("abort no frame_done later", frame_done, 0);
        run_frame(frames[0], "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
